alu_control: RTL and testbench

ALU control decoder for the 16-bit single-cycle datapath.
- Maps the main control unit's 2-bit ALUOp and the instruction's 4-bit function field to a 3-bit ALU operation select (Operacioni).
- Sits between the control unit / instruction decode and the ALU.
- Output is registered: one clock of latency, plus a valid flag and an illegal-encoding flag.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_control_if.sv | 11 +
 rtl/alu_funct_decode.sv | 23 ++
 rtl/alu_control.sv | 37 +++
 tb/tb_alu_control.sv | 128 ++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation, ALUOp class and R-type Funct encodings.
package alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [1:0] ALUOP_MEM  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;
  localparam logic [1:0] ALUOP_SLTI = 2'b11;
  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0001;
  localparam logic [3:0] FUNCT_SLT = 4'b0010;
  localparam logic [3:0] FUNCT_AND = 4'b1100;
  localparam logic [3:0] FUNCT_OR  = 4'b1101;
  localparam logic [3:0] FUNCT_XOR = 4'b1110;
  localparam logic [3:0] FUNCT_NOR = 4'b1111;
endpackage

// File: rtl/alu_control_if.sv
// alu_control_if: decode request from control/decode and registered ALU select back.
interface alu_control_if;
  logic [1:0] ALUOp;
  logic [3:0] Funct;
  logic       in_valid;
  logic [2:0] Operacioni;
  logic       out_valid;
  logic       illegal;
  modport master (output ALUOp, Funct, in_valid, input Operacioni, out_valid, illegal);
  modport slave  (input ALUOp, Funct, in_valid, output Operacioni, out_valid, illegal);
endinterface

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: pure combinational R-type Funct to ALU op; unknown Funct gives ADD and flags illegal.
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [3:0] funct,
  output logic [2:0] op,
  output logic       illegal
);
  always_comb begin
    op = OP_ADD;
    illegal = 1'b0;
    case (funct)
      FUNCT_ADD: op = OP_ADD;
      FUNCT_SUB: op = OP_SUB;
      FUNCT_SLT: op = OP_SLT;
      FUNCT_AND: op = OP_AND;
      FUNCT_OR:  op = OP_OR;
      FUNCT_XOR: op = OP_XOR;
      FUNCT_NOR: op = OP_NOR;
      default:   illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_control.sv
// alu_control: ALUOp/Funct to ALU operation select, registered with valid and illegal flags.
module alu_control
  import alu_pkg::*;
#(
  parameter logic [2:0] RESET_OP = OP_ADD
) (
  input logic          clk,
  input logic          rst_n,
  alu_control_if.slave bus
);
  logic [2:0] r_op, dec_op, op_d, op_q;
  logic       r_ill, dec_ill, ill_d, ill_q, vld_d, vld_q;
  alu_funct_decode u_dec (.funct(bus.Funct), .op(r_op), .illegal(r_ill));
  // ALUOp is tested first so Funct never reaches the outputs for non-R classes
  always_comb begin
    dec_op  = bus.ALUOp == ALUOP_MEM  ? OP_ADD :
              bus.ALUOp == ALUOP_BR   ? OP_SUB :
              bus.ALUOp == ALUOP_SLTI ? OP_SLT : r_op;
    dec_ill = bus.ALUOp == ALUOP_R ? r_ill : 1'b0;
    op_d    = bus.in_valid ? dec_op : op_q;
    ill_d   = bus.in_valid ? dec_ill : ill_q;
    vld_d   = bus.in_valid;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q  <= RESET_OP;
      ill_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      ill_q <= ill_d;
      vld_q <= vld_d;
    end
  assign bus.Operacioni = op_q;
  assign bus.illegal    = ill_q;
  assign bus.out_valid  = vld_q;
endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: randomized + directed scoreboard bench against a table-driven reference model.
module tb_alu_control;
  typedef struct {logic v; logic [2:0] op; logic ill;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [2:0] rtab [16];
  logic       rlegal [16];
  logic [2:0] cls [4];
  logic [2:0] m_op = 3'b010;
  logic       m_ill = 1'b0;
  alu_control_if bus();
  alu_control #(.RESET_OP(3'b010)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic v, input logic [1:0] a, input logic [3:0] f);
    exp_t e;
    bus.in_valid = v;
    bus.ALUOp = a;
    bus.Funct = f;
    if (v) begin
      m_op  = (a == 2'b10) ? rtab[f] : cls[a];
      m_ill = (a == 2'b10) ? !rlegal[f] : 1'b0;
    end
    e.v = v;
    e.op = m_op;
    e.ill = m_ill;
    q.push_back(e);
    @(negedge clk);
  endtask
  // monitor: one result per clock, checked just after the capturing edge
  initial forever begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      chk("no_x", {31'd0, $isunknown({bus.Operacioni, bus.out_valid, bus.illegal})}, 0);
      chk("op_not_101", {31'd0, bus.Operacioni == 3'b101}, 0);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mon_e.v});
        chk("Operacioni", {29'd0, bus.Operacioni}, {29'd0, mon_e.op});
        chk("illegal", {31'd0, bus.illegal}, {31'd0, mon_e.ill});
      end else
        chk("idle_out_valid", {31'd0, bus.out_valid}, 0);
    end
  end
  initial begin
    for (int i = 0; i < 16; i++) begin
      rtab[i] = 3'b010;
      rlegal[i] = 1'b0;
    end
    rtab[0] = 3'b010;  rlegal[0] = 1'b1;
    rtab[1] = 3'b110;  rlegal[1] = 1'b1;
    rtab[2] = 3'b111;  rlegal[2] = 1'b1;
    rtab[12] = 3'b000; rlegal[12] = 1'b1;
    rtab[13] = 3'b001; rlegal[13] = 1'b1;
    rtab[14] = 3'b011; rlegal[14] = 1'b1;
    rtab[15] = 3'b100; rlegal[15] = 1'b1;
    cls[0] = 3'b010; cls[1] = 3'b110; cls[2] = 3'b010; cls[3] = 3'b111;
    bus.in_valid = 1'b0;
    bus.ALUOp = 2'b00;
    bus.Funct = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.ALUOp = 2'($urandom);
      bus.Funct = 4'($urandom);
      @(posedge clk);
      #1;
      chk("rst_op", {29'd0, bus.Operacioni}, 32'h2);
      chk("rst_valid", {31'd0, bus.out_valid}, 0);
      chk("rst_illegal", {31'd0, bus.illegal}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    mon_en = 1'b1;
    drive(1, 2'b00, 4'bxxxx);
    drive(1, 2'b01, 4'bxxxx);
    drive(1, 2'b11, 4'bxxxx);
    drive(1, 2'b10, 4'b1111);
    drive(1, 2'b10, 4'b1110);
    drive(1, 2'b10, 4'b1101);
    drive(1, 2'b10, 4'b0000);
    drive(1, 2'b10, 4'b0001);
    drive(1, 2'b10, 4'b1100);
    drive(1, 2'b10, 4'b0010);
    drive(1, 2'b10, 4'b0101);
    drive(1, 2'b10, 4'b0001);
    drive(1, 2'b01, 4'($urandom));
    drive(0, 2'b10, 4'b1100);
    drive(0, 2'b00, 4'b0000);
    for (int i = 0; i < 64; i++)
      drive(1, 2'(i >> 4), 4'(i));
    for (int i = 0; i < 300; i++)
      drive(1'($urandom), 2'($urandom), 4'($urandom));
    drive(0, 2'b00, 4'b0000);
    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(negedge clk);
    chk("drain", q.size(), 0);
    drive(1, 2'b01, 4'($urandom));
    mon_en = 1'b0;
    bus.in_valid = 1'b1;
    bus.ALUOp = 2'b11;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_op", {29'd0, bus.Operacioni}, 32'h2);
    chk("async_rst_valid", {31'd0, bus.out_valid}, 0);
    chk("async_rst_illegal", {31'd0, bus.illegal}, 0);
    @(posedge clk);
    #1;
    chk("dropped_op", {29'd0, bus.Operacioni}, 32'h2);
    chk("dropped_valid", {31'd0, bus.out_valid}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
